backscatter_sequencer: RTL and testbench
========================================

Name: backscatter_sequencer

Overview:
- Frame controller for the tag backscatter datapath (data_source -> whitening -> dbpsk_modulator -> RF switch), running on the ref clock.
- Waits for a qualified rising edge of the demodulator's packet-detect level, then skips the excitation packet's preamble/header for a programmable number of bit periods.
- Opens the modulation window for the latched payload length, strobing one bit per bit period, then enforces a guard interval before re-arming.
- Aborts cleanly when the carrier packet ends early.

Parameters:
- CLKS_PER_BIT, 20, clock cycles per backscatter bit period (>=2)
- DELAY_BITS, 192, bit periods from detect to first payload bit (>=1)
- GUARD_BITS, 8, bit periods held in guard after payload or abort (>=1)
- LEN_W, 10, width of payload length and bit index

Ports:
- clock  in  1  ref clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  permits new frames to start; sampled only in IDLE
- packet_detect  in  1  demodulator "sending" level, same clock domain
- payload_len  in  LEN_W  payload bits; latched at frame start
- busy  out  1  high in any state other than IDLE
- load_data  out  1  one-cycle pulse; data_source captures its word
- whiten_init  out  1  one-cycle pulse; whitening reseeds its LFSR
- mod_enable  out  1  modulation window, drives trigger of data/whitening/dbpsk
- switch_sel  out  1  selects modulated path into the RF switch; equals mod_enable
- bit_strobe  out  1  one-cycle pulse at the start of each payload bit
- bit_index  out  LEN_W  index of the current payload bit, 0-based
- frame_done  out  1  one-cycle pulse when the payload completes
- abort  out  1  one-cycle pulse when the frame is aborted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; clk_cnt, bit_cnt and len_q are cleared.
  - All outputs are 0.
  - det_q is set to 1, so a detect already high at reset release does not start a frame.
- Edge detect: det_q is packet_detect registered. rise = packet_detect & ~det_q.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps; bit_cnt increments at each wrap.
  - Both counters clear on every state change.
- IDLE:
  - If rise and enable: len_q <= payload_len, then go to DELAY.
  - Otherwise stay in IDLE. A detect held high across a whole frame never restarts one; a new rising edge is required.
- DELAY:
  - load_data and whiten_init are high in the first DELAY cycle only.
  - After DELAY_BITS*CLKS_PER_BIT cycles, go to SEND, or to GUARD with frame_done if len_q==0.
  - If packet_detect=0 in any DELAY cycle: go to GUARD and pulse abort in the first GUARD cycle.
- SEND:
  - mod_enable=switch_sel=1 for exactly len_q*CLKS_PER_BIT cycles.
  - bit_strobe is high when clk_cnt==0. bit_index=bit_cnt and holds for the whole bit.
  - On completion, go to GUARD; frame_done is high in the first GUARD cycle.
  - If packet_detect=0 in any SEND cycle: mod_enable drops the next cycle, the state goes to GUARD, abort pulses, and there is no frame_done.
  - abort has priority over completion in the same cycle.
- GUARD:
  - Lasts GUARD_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - packet_detect and enable are ignored.
- Other rules:
  - bit_index is 0 outside SEND.
  - enable deasserting mid-frame does not abort.
  - payload_len changes after the start are ignored.
  - All outputs are decoded from registered state and counters: glitch-free, no combinational input-to-output paths.

Decomposition:
- Shared package:
  - state enum {IDLE, DELAY, SEND, GUARD}, 2-bit.
  - Default constants CLKS_PER_BIT/DELAY_BITS/GUARD_BITS.
  - LEN_W, shared with data_source input_data width.
- Sub-module bit_timer:
  - Contains the clk_cnt divider with synchronous clear.
  - Outputs bit_start (clk_cnt==0) and bit_end (clk_cnt==CLKS_PER_BIT-1).
  - The FSM and bit_cnt stay in the top module.

Test Plan (CLKS_PER_BIT=4, DELAY_BITS=3, GUARD_BITS=2; rise sampled at edge t):
- Nominal, len=5, detect held high: DELAY t+1..t+12 (load_data and whiten_init at t+1) -> SEND t+13..t+32, bit_strobe at t+13,17,21,25,29 with bit_index 0..4 -> frame_done at t+33 -> GUARD t+33..t+40 -> IDLE at t+41, busy low.
- Abort in SEND: len=5, detect dropped at t+20 -> mod_enable low at t+21, abort=1 at t+21, no frame_done, IDLE at t+29.
- Zero length and enable gating: len=0 -> no mod_enable, frame_done at t+13, IDLE at t+21. Edge with enable=0 -> busy stays 0.
- Re-arm: detect held high through the end of the frame -> no new frame. Drop for 1 cycle then raise -> new frame starts. Detect high during reset release -> no frame.
- Async reset asserted mid-SEND -> all outputs 0 immediately, state IDLE. Changing payload_len during DELAY -> SEND length still equals the latched value.

Source files
------------

// File: rtl/backscatter_sequencer_pkg.sv
// Shared types and defaults for the backscatter frame sequencer.
package backscatter_sequencer_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Default timing; LEN_W also sizes the data_source input word
  localparam int DEF_CLKS_PER_BIT = 20;
  localparam int DEF_DELAY_BITS   = 192;
  localparam int DEF_GUARD_BITS   = 8;
  localparam int DEF_LEN_W        = 10;

  // Bits needed to hold values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/backscatter_sequencer_bit_timer.sv
// Bit-period divider: clk_cnt runs 0..CLKS_PER_BIT-1 and wraps,
// with a synchronous clear used on every frame-state change.
module backscatter_sequencer_bit_timer
  import backscatter_sequencer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_start,
  output logic bit_end
);

  localparam int CW = cnt_width(CLKS_PER_BIT);

  logic [CW-1:0] clk_cnt;

  // Divider counter: clear wins, otherwise wrap at the end of a bit period
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_cnt <= '0;
    end else if (clear || bit_end) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  // Bit-period boundary decodes from the registered count
  always_comb begin
    bit_start = (clk_cnt == '0);
    bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  end

endmodule

// File: rtl/backscatter_sequencer.sv
// Frame controller for the tag backscatter datapath: waits for a new
// packet-detect edge, skips the excitation preamble, opens the modulation
// window for the latched payload length, then holds a guard interval.
module backscatter_sequencer
  import backscatter_sequencer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DELAY_BITS   = DEF_DELAY_BITS,
  parameter int GUARD_BITS   = DEF_GUARD_BITS,
  parameter int LEN_W        = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             packet_detect,
  input  logic [LEN_W-1:0] payload_len,
  output logic             busy,
  output logic             load_data,
  output logic             whiten_init,
  output logic             mod_enable,
  output logic             switch_sel,
  output logic             bit_strobe,
  output logic [LEN_W-1:0] bit_index,
  output logic             frame_done,
  output logic             abort,
  output state_t           state_dbg
);

  // bit_cnt must cover the delay, the guard and the longest payload
  localparam int BC_W = max3(LEN_W, cnt_width(DELAY_BITS), cnt_width(GUARD_BITS));

  state_t           state;
  state_t           state_next;
  logic             det_q;
  logic             rise;
  logic [LEN_W-1:0] len_q;
  logic [BC_W-1:0]  bit_cnt;
  logic             bit_start;
  logic             bit_end;
  logic             cnt_clear;
  logic             done_q;
  logic             abort_q;
  logic             done_next;
  logic             abort_next;
  logic             delay_last;
  logic             send_last;
  logic             guard_last;

  assign rise       = packet_detect & ~det_q;
  assign delay_last = bit_end && (bit_cnt == BC_W'(DELAY_BITS - 1));
  assign send_last  = bit_end && (bit_cnt == (BC_W'(len_q) - BC_W'(1)));
  assign guard_last = bit_end && (bit_cnt == BC_W'(GUARD_BITS - 1));
  // Counters restart on every state change; IDLE holds them at zero
  assign cnt_clear  = (state_next != state) || (state == IDLE);
  assign state_dbg  = state;

  backscatter_sequencer_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .bit_start (bit_start),
    .bit_end   (bit_end)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a carrier drop takes priority over completion
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        if (rise && enable) state_next = DELAY;
      end
      DELAY: begin
        if (!packet_detect) begin
          state_next = GUARD;
          abort_next = 1'b1;
        end else if (delay_last) begin
          if (len_q == '0) begin
            state_next = GUARD;
            done_next  = 1'b1;
          end else begin
            state_next = SEND;
          end
        end
      end
      SEND: begin
        if (!packet_detect) begin
          state_next = GUARD;
          abort_next = 1'b1;
        end else if (send_last) begin
          state_next = GUARD;
          done_next  = 1'b1;
        end
      end
      GUARD: begin
        if (guard_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge detector, length latch and first-GUARD-cycle status pulses;
  // det_q resets high so a detect already present at release is ignored
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_q   <= 1'b1;
      len_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      det_q   <= packet_detect;
      done_q  <= done_next;
      abort_q <= abort_next;
      if (state == IDLE && state_next == DELAY) len_q <= payload_len;
    end
  end

  // Bit counter: advances at each bit-period wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (cnt_clear) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  // Outputs decoded from registered state and counters only
  always_comb begin
    busy        = (state != IDLE);
    load_data   = (state == DELAY) && bit_start && (bit_cnt == '0);
    whiten_init = load_data;
    mod_enable  = (state == SEND);
    switch_sel  = mod_enable;
    bit_strobe  = mod_enable && bit_start;
    bit_index   = mod_enable ? bit_cnt[LEN_W-1:0] : '0;
    frame_done  = done_q;
    abort       = abort_q;
  end

endmodule

// File: tb/tb_backscatter_sequencer.sv
// Directed bench for backscatter_sequencer with a bit-index scoreboard.
module tb_backscatter_sequencer;
  import backscatter_sequencer_pkg::*;

  localparam int CPB = 4;
  localparam int DB  = 3;
  localparam int GB  = 2;
  localparam int LW  = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          packet_detect = 1'b0;
  logic [LW-1:0] payload_len = '0;
  logic          busy, load_data, whiten_init, mod_enable, switch_sel;
  logic          bit_strobe, frame_done, abort;
  logic [LW-1:0] bit_index;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q[$];

  backscatter_sequencer #(
    .CLKS_PER_BIT (CPB),
    .DELAY_BITS   (DB),
    .GUARD_BITS   (GB),
    .LEN_W        (LW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .packet_detect (packet_detect),
    .payload_len   (payload_len),
    .busy          (busy),
    .load_data     (load_data),
    .whiten_init   (whiten_init),
    .mod_enable    (mod_enable),
    .switch_sel    (switch_sel),
    .bit_strobe    (bit_strobe),
    .bit_index     (bit_index),
    .frame_done    (frame_done),
    .abort         (abort),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {14'd0, busy, load_data, whiten_init, mod_enable, switch_sel,
            bit_strobe, frame_done, abort, bit_index};
  endfunction

  function automatic logic [31:0] mk_vec(input logic b, input logic l, input logic m,
                                         input logic st, input logic d, input logic a,
                                         input logic [LW-1:0] idx);
    return {14'd0, b, l, l, m, m, st, d, a, idx};
  endfunction

  // Frame starting from IDLE with det_q low. drop_at>0 drives detect low
  // during observed cycle drop_at (cycle 1 = first cycle after the rise edge).
  task automatic run_frame(input int len, input int drop_at, input bit change_len);
    int d_end;
    int s_end;
    int g_start;
    int idle_at;
    bit aborted;
    bit e_mod;
    bit e_st;
    logic [LW-1:0] e_idx;
    d_end = DB * CPB;
    s_end = d_end + len * CPB;
    if (drop_at > 0 && drop_at <= d_end) begin
      g_start = drop_at + 1;
      aborted = 1'b1;
    end else if (len > 0 && drop_at > 0 && drop_at <= s_end) begin
      g_start = drop_at + 1;
      aborted = 1'b1;
    end else begin
      g_start = s_end + 1;
      aborted = 1'b0;
    end
    idle_at = g_start + GB * CPB;
    for (int k = 0; k < len; k++) begin
      if (d_end + 1 + k * CPB < g_start) exp_q.push_back(LW'(k));
    end
    payload_len   = LW'(len);
    packet_detect = 1'b1;
    tick();
    for (int n = 1; n <= idle_at; n++) begin
      e_mod = (n > d_end) && (n < g_start);
      e_st  = e_mod && (((n - d_end - 1) % CPB) == 0);
      e_idx = e_mod ? LW'((n - d_end - 1) / CPB) : '0;
      check("cycle_outputs", out_vec(),
            mk_vec(n < idle_at, n == 1, e_mod, e_st,
                   (n == g_start) && !aborted, (n == g_start) && aborted, e_idx));
      if (bit_strobe) begin
        if (exp_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else check("bit_index_sb", 32'(bit_index), 32'(exp_q.pop_front()));
      end
      if (n == drop_at) packet_detect = 1'b0;
      if (change_len && n == 3) payload_len = LW'($urandom_range(1, 1023));
      if (n == 5 && n < g_start) enable = 1'b0;
      if (n == g_start) enable = 1'b1;
      if (n < idle_at) tick();
    end
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("state_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    // Reset with detect already high
    reset = 1'b0;
    enable = 1'b1;
    packet_detect = 1'b1;
    tick();
    tick();
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("detect_at_release", 32'(busy), 32'd0);
    end
    packet_detect = 1'b0;
    tick();

    // Nominal frame with payload_len changed during DELAY
    run_frame(5, 0, 1'b1);

    // Detect still high: no new frame
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_detect_no_restart", 32'(busy), 32'd0);
    end
    packet_detect = 1'b0;
    tick();

    // Abort in SEND
    run_frame(5, 20, 1'b0);

    // Zero length
    run_frame(0, 0, 1'b0);
    packet_detect = 1'b0;
    tick();

    // Abort in DELAY
    run_frame(3, 6, 1'b0);

    // Edge while disabled
    enable = 1'b0;
    packet_detect = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("enable_gating", 32'(busy), 32'd0);
    end
    packet_detect = 1'b0;
    enable = 1'b1;
    tick();

    // Random lengths, re-arm after a one-cycle drop each time
    for (int i = 0; i < 3; i++) begin
      run_frame($urandom_range(1, 6), 0, 1'b1);
      packet_detect = 1'b0;
      tick();
    end

    // Async reset in the middle of SEND
    payload_len = LW'(4);
    packet_detect = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("mid_send_mod", 32'(mod_enable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 32'd0);
    check("async_reset_state", 32'(state_dbg), 32'(IDLE));
    tick();
    check("reset_held_outputs", out_vec(), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_idle", 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
